// File: rtl/immediate_gen_pipe.sv
// -----------------------------------------------------------------------------
// immediate_gen_pipe
//
// Decode-stage immediate generator with a registered valid/ready output.
// Each accepted instruction is decoded into its RISC-V immediate (U/J/I/B/S,
// SHAMT or ZIMM), extended to XLEN, and paired with the PC-relative target
// PC+imm. Results sit in a 2-entry skid buffer. Decode therefore keeps full
// throughput while the consumer is ready, and no entry is lost when the
// consumer stalls.
//
// Ports
//   CLK          in   clock, rising edge
//   RESET        in   synchronous active-high reset (priority over FLUSH)
//   FLUSH        in   drop every buffered entry and the entry offered this cycle
//   IN_VALID     in   INSTRUCTION/SELECT/PC are valid
//   IN_READY     out  block can accept (registered)
//   INSTRUCTION  in   raw 32-bit instruction word
//   SELECT       in   [2:0] immediate type, [3] 1 = zero-extend
//   PC           in   PC of INSTRUCTION
//   OUT_VALID    out  output entry valid
//   OUT_READY    in   consumer accepts the entry
//   OUT_IMM      out  extended immediate
//   OUT_TARGET   out  PC+OUT_IMM (or PC for SHAMT/ZIMM/illegal)
//   OUT_ERR      out  SELECT[2:0] was the illegal code 111
// -----------------------------------------------------------------------------
module immediate_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTRUCTION,
    input  logic [3:0]      SELECT,
    input  logic [XLEN-1:0] PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT_IMM,
    output logic [XLEN-1:0] OUT_TARGET,
    output logic            OUT_ERR
);

    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic            sign_bit;
    logic            pc_rel;
    logic            err_dec;
    logic [XLEN-1:0] imm_dec;
    logic [XLEN-1:0] target_dec;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^INSTRUCTION[6:0];

    always_comb begin
        imm32    = '0;
        pc_rel   = 1'b0;
        err_dec  = 1'b0;
        // Every signed field has its MSB at instruction bit 31.
        sign_bit = INSTRUCTION[31] & ~SELECT[3];
        case (SELECT[2:0])
            3'b000: begin
                imm32  = {INSTRUCTION[31:12], 12'b0};
                pc_rel = 1'b1;
            end
            3'b001: begin
                imm32  = {{11{sign_bit}}, INSTRUCTION[31], INSTRUCTION[19:12],
                          INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
                pc_rel = 1'b1;
            end
            3'b010: begin
                imm32  = {{20{sign_bit}}, INSTRUCTION[31:20]};
                pc_rel = 1'b1;
            end
            3'b011: begin
                imm32  = {{19{sign_bit}}, INSTRUCTION[31], INSTRUCTION[7],
                          INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
                pc_rel = 1'b1;
            end
            3'b100: begin
                imm32  = {{20{sign_bit}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
                pc_rel = 1'b1;
            end
            3'b101: begin
                imm32[SHAMT_W-1:0] = INSTRUCTION[20 +: SHAMT_W];
            end
            3'b110: begin
                imm32 = {27'b0, INSTRUCTION[19:15]};
            end
            default: begin
                err_dec = 1'b1;
            end
        endcase

        // Bits above 31 only exist for XLEN=64; they follow the sign of the
        // PC-relative types and stay zero for SHAMT/ZIMM/illegal.
        imm_dec        = {XLEN{sign_bit & pc_rel}};
        imm_dec[31:0]  = imm32;
        target_dec     = pc_rel ? (PC + imm_dec) : PC;
    end

    // ------------------------------------------------------------------
    // Occupancy FSM and main (output) entry
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] target_reg;
    logic            err_reg;

    logic [XLEN-1:0] skid_imm_reg;
    logic [XLEN-1:0] skid_target_reg;
    logic            skid_err_reg;

    logic push;
    logic pop;

    assign push = IN_VALID & in_ready_reg;
    assign pop  = out_valid_reg & OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            imm_reg       <= '0;
            target_reg    <= '0;
            err_reg       <= 1'b0;
        end else if (FLUSH) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        imm_reg       <= imm_dec;
                        target_reg    <= target_dec;
                        err_reg       <= err_dec;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        // Consumer stalled: park the new entry in the skid slot.
                        state_reg    <= TWO;
                        in_ready_reg <= 1'b0;
                    end else if (pop && !push) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end else if (push && pop) begin
                        imm_reg    <= imm_dec;
                        target_reg <= target_dec;
                        err_reg    <= err_dec;
                    end
                end
                TWO: begin
                    if (pop) begin
                        imm_reg      <= skid_imm_reg;
                        target_reg   <= skid_target_reg;
                        err_reg      <= skid_err_reg;
                        state_reg    <= ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Skid slot holds no architectural state until the FSM says so, so it
    // needs no reset and may load even in a cycle that is reset or flushed.
    always_ff @(posedge CLK) begin
        if (state_reg == ONE && push && !pop) begin
            skid_imm_reg    <= imm_dec;
            skid_target_reg <= target_dec;
            skid_err_reg    <= err_dec;
        end
    end

    assign IN_READY   = in_ready_reg;
    assign OUT_VALID  = out_valid_reg;
    assign OUT_IMM    = imm_reg;
    assign OUT_TARGET = target_reg;
    assign OUT_ERR    = err_reg;

endmodule

// File: tb/tb_immediate_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immediate_gen_pipe
//
// Directed-vector bench for immediate_gen_pipe. A 32-bit instance covers decode,
// handshake, flush and reset. A 64-bit instance covers the U-type upper-bit
// extension. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_immediate_gen_pipe;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic        FLUSH;

    // 32-bit instance signals
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [3:0]  sel;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic        out_err;

    // 64-bit instance signals
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] instr64;
    logic [3:0]  sel64;
    logic [63:0] pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [63:0] out_target64;
    logic        out_err64;

    int n_cmp = 0;
    int n_bad = 0;

    immediate_gen_pipe #(.XLEN(32)) dut32 (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .INSTRUCTION (instr),
        .SELECT      (sel),
        .PC          (pc),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_IMM     (out_imm),
        .OUT_TARGET  (out_target),
        .OUT_ERR     (out_err)
    );

    immediate_gen_pipe #(.XLEN(64)) dut64 (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (1'b0),
        .IN_VALID    (in_valid64),
        .IN_READY    (in_ready64),
        .INSTRUCTION (instr64),
        .SELECT      (sel64),
        .PC          (pc64),
        .OUT_VALID   (out_valid64),
        .OUT_READY   (out_ready64),
        .OUT_IMM     (out_imm64),
        .OUT_TARGET  (out_target64),
        .OUT_ERR     (out_err64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // I-type instruction carrying a 12-bit immediate (addi x1, x0, imm).
    function automatic logic [31:0] i_instr(input logic [11:0] imm12);
        return {imm12, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    // Single decode through the 32-bit instance with the consumer ready.
    task automatic decode32(input string tag, input logic [31:0] ins, input logic [3:0] s,
                            input logic [31:0] p, input logic [31:0] e_imm,
                            input logic [31:0] e_tgt, input logic e_err);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = ins;
        sel       = s;
        pc        = p;
        tick();
        in_valid = 1'b0;
        $display("txn %s: instr=0x%08h sel=%b pc=0x%0h -> imm=0x%08h target=0x%08h err=%0b",
                 tag, ins, s, p, out_imm, out_target, out_err);
        check({tag, ".valid"},  {63'd0, out_valid}, 64'd1);
        check({tag, ".imm"},    {32'd0, out_imm},    {32'd0, e_imm});
        check({tag, ".target"}, {32'd0, out_target}, {32'd0, e_tgt});
        check({tag, ".err"},    {63'd0, out_err},    {63'd0, e_err});
        tick();
    endtask

    task automatic decode64(input string tag, input logic [31:0] ins, input logic [3:0] s,
                            input logic [63:0] p, input logic [63:0] e_imm,
                            input logic [63:0] e_tgt);
        out_ready64 = 1'b1;
        in_valid64  = 1'b1;
        instr64     = ins;
        sel64       = s;
        pc64        = p;
        tick();
        in_valid64 = 1'b0;
        $display("txn %s: instr=0x%08h sel=%b pc=0x%0h -> imm=0x%016h target=0x%016h",
                 tag, ins, s, p, out_imm64, out_target64);
        check({tag, ".valid"},  {63'd0, out_valid64}, 64'd1);
        check({tag, ".imm"},    out_imm64,    e_imm);
        check({tag, ".target"}, out_target64, e_tgt);
        tick();
    endtask

    initial begin
        RESET       = 1'b1;
        FLUSH       = 1'b0;
        in_valid    = 1'b0;
        instr       = '0;
        sel         = '0;
        pc          = '0;
        out_ready   = 1'b0;
        in_valid64  = 1'b0;
        instr64     = '0;
        sel64       = '0;
        pc64        = '0;
        out_ready64 = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        $display("txn reset: valid=%0b ready=%0b imm=0x%0h", out_valid, in_ready, out_imm);
        check("rst.valid",   {63'd0, out_valid},   64'd0);
        check("rst.ready",   {63'd0, in_ready},    64'd1);
        check("rst.imm",     {32'd0, out_imm},     64'd0);
        check("rst.target",  {32'd0, out_target},  64'd0);
        check("rst.err",     {63'd0, out_err},     64'd0);
        check("rst.valid64", {63'd0, out_valid64}, 64'd0);
        RESET = 1'b0;
        tick();

        // ---------------- decode values ----------------
        decode32("j",      32'h0080006F, 4'b0001, 32'h200, 32'h00000008, 32'h00000208, 1'b0);
        decode32("i",      32'hFFF00093, 4'b0010, 32'h010, 32'hFFFFFFFF, 32'h0000000F, 1'b0);
        decode32("shamt",  32'h41F0D093, 4'b0101, 32'h300, 32'h0000001F, 32'h00000300, 1'b0);
        decode32("b_s",    32'hFE000EE3, 4'b0011, 32'h100, 32'hFFFFFFFC, 32'h000000FC, 1'b0);
        decode32("b_u",    32'hFE000EE3, 4'b1011, 32'h100, 32'h00001FFC, 32'h000020FC, 1'b0);
        decode32("u32",    32'h12345037, 4'b0000, 32'h010, 32'h12345000, 32'h12345010, 1'b0);
        decode32("s_s",    32'hFE112E23, 4'b0100, 32'h020, 32'hFFFFFFFC, 32'h0000001C, 1'b0);
        decode32("s_u",    32'hFE112E23, 4'b1100, 32'h020, 32'h00000FFC, 32'h0000101C, 1'b0);
        decode32("zimm",   32'h0007D073, 4'b0110, 32'h040, 32'h0000000F, 32'h00000040, 1'b0);
        decode32("zimm_u", 32'h0007D073, 4'b1110, 32'h040, 32'h0000000F, 32'h00000040, 1'b0);
        decode32("ill",    32'h12345678, 4'b0111, 32'h044, 32'h00000000, 32'h00000044, 1'b1);
        decode32("ill_u",  32'hFFFFFFFF, 4'b1111, 32'h048, 32'h00000000, 32'h00000048, 1'b1);
        decode64("u64_s",  32'h800000B7, 4'b0000, 64'h1000,
                 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000);
        decode64("u64_u",  32'h800000B7, 4'b1000, 64'h1000,
                 64'h0000000080000000, 64'h0000000080001000);
        decode64("i64_s",  32'hFFF00093, 4'b0010, 64'h10,
                 64'hFFFFFFFFFFFFFFFF, 64'h000000000000000F);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        pc        = 32'h1000;
        sel       = 4'b0010;
        in_valid  = 1'b1;
        instr     = i_instr(12'h0A1);
        tick();
        $display("txn bp.a: ready=%0b valid=%0b imm=0x%0h", in_ready, out_valid, out_imm);
        check("bp.a.ready", {63'd0, in_ready}, 64'd1);
        check("bp.a.imm",   {32'd0, out_imm},  64'h0A1);
        instr = i_instr(12'h0B2);
        tick();
        $display("txn bp.b: ready=%0b valid=%0b imm=0x%0h", in_ready, out_valid, out_imm);
        check("bp.b.ready", {63'd0, in_ready}, 64'd0);
        check("bp.b.hold",  {32'd0, out_imm},  64'h0A1);
        instr = i_instr(12'h0C3);
        tick();
        $display("txn bp.c: ready=%0b valid=%0b imm=0x%0h", in_ready, out_valid, out_imm);
        check("bp.c.ready",  {63'd0, in_ready},   64'd0);
        check("bp.c.hold",   {32'd0, out_imm},    64'h0A1);
        check("bp.c.target", {32'd0, out_target}, 64'h10A1);
        out_ready = 1'b1;
        tick();
        $display("txn bp.out1: ready=%0b valid=%0b imm=0x%0h", in_ready, out_valid, out_imm);
        check("bp.out1.valid", {63'd0, out_valid}, 64'd1);
        check("bp.out1.imm",   {32'd0, out_imm},   64'h0B2);
        check("bp.out1.ready", {63'd0, in_ready},  64'd1);
        tick();
        in_valid = 1'b0;
        $display("txn bp.out2: ready=%0b valid=%0b imm=0x%0h", in_ready, out_valid, out_imm);
        check("bp.out2.valid",  {63'd0, out_valid},  64'd1);
        check("bp.out2.imm",    {32'd0, out_imm},    64'h0C3);
        check("bp.out2.target", {32'd0, out_target}, 64'h10C3);
        tick();
        check("bp.drain.valid", {63'd0, out_valid}, 64'd0);

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            instr = i_instr(12'(k));
            pc    = 32'h2000 + 32'(k * 4);
            tick();
            $display("txn stream%0d: valid=%0b ready=%0b imm=0x%0h target=0x%0h",
                     k, out_valid, in_ready, out_imm, out_target);
            check("stream.valid",  {63'd0, out_valid},  64'd1);
            check("stream.imm",    {32'd0, out_imm},    64'(k));
            check("stream.target", {32'd0, out_target}, 64'(32'h2000 + k * 5));
            check("stream.ready",  {63'd0, in_ready},   64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream.end.valid", {63'd0, out_valid}, 64'd0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        pc        = 32'h0;
        in_valid  = 1'b1;
        instr     = i_instr(12'h011);
        tick();
        instr = i_instr(12'h022);
        tick();
        check("fl.two.ready", {63'd0, in_ready}, 64'd0);
        instr = i_instr(12'h033);
        FLUSH = 1'b1;
        tick();
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        $display("txn flush.two: valid=%0b ready=%0b", out_valid, in_ready);
        check("fl.two.valid",  {63'd0, out_valid}, 64'd0);
        check("fl.two.ready2", {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        tick();
        check("fl.two.none", {63'd0, out_valid}, 64'd0);
        // Flush while empty and ready: the offered entry must still be dropped.
        in_valid = 1'b1;
        instr    = i_instr(12'h044);
        FLUSH    = 1'b1;
        tick();
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        $display("txn flush.empty: valid=%0b ready=%0b", out_valid, in_ready);
        check("fl.empty.valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("fl.empty.none", {63'd0, out_valid}, 64'd0);
        decode32("post_flush", i_instr(12'h055), 4'b0010, 32'h0, 32'h55, 32'h55, 1'b0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        pc        = 32'h0;
        sel       = 4'b0010;
        in_valid  = 1'b1;
        instr     = i_instr(12'h066);
        tick();
        instr = i_instr(12'h077);
        tick();
        check("rs.two.ready", {63'd0, in_ready}, 64'd0);
        check("rs.two.imm",   {32'd0, out_imm},  64'h066);
        instr = i_instr(12'h088);
        RESET = 1'b1;
        FLUSH = 1'b1;
        tick();
        RESET    = 1'b0;
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        $display("txn reset.mid: valid=%0b ready=%0b imm=0x%0h target=0x%0h",
                 out_valid, in_ready, out_imm, out_target);
        check("rs.valid",  {63'd0, out_valid},  64'd0);
        check("rs.ready",  {63'd0, in_ready},   64'd1);
        check("rs.imm",    {32'd0, out_imm},    64'd0);
        check("rs.target", {32'd0, out_target}, 64'd0);
        check("rs.err",    {63'd0, out_err},    64'd0);
        out_ready = 1'b1;
        tick();
        check("rs.none", {63'd0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
